// File: rtl/rx_port_arbiter_pkg.sv
// Shared constants and helpers for the RX port arbiter: AXIS widths, FSM states,
// and the round-robin pointer advance.
package rx_port_arbiter_pkg;

  localparam int AXIS_DATA_W = 64;
  localparam int AXIS_STRB_W = 8;

  typedef enum logic {
    ARB_ST_ARB = 1'b0,
    ARB_ST_PKT = 1'b1
  } arb_state_e;

  // Pointer lands one past the port that just finished, wrapping to 0.
  function automatic int rr_next(input int port, input int num_ports);
    return (port >= num_ports - 1) ? 0 : port + 1;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered valid/ready buffer: output register plus one skid slot.
// Ready is registered, so it drops the cycle after a beat lands in the skid slot.
module axis_skid_buffer #(
  parameter int WIDTH = 76
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_s_data,
  input  logic             i_s_valid,
  output logic             o_s_ready,
  output logic [WIDTH-1:0] o_m_data,
  output logic             o_m_valid,
  input  logic             i_m_ready
);

  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_skid;
  logic             r_out_vld;
  logic             r_skid_vld;
  logic             r_rdy;
  logic             w_drain;
  logic             w_take;
  logic             w_skid_vld_n;

  assign w_drain   = i_m_ready | ~r_out_vld;
  assign w_take    = i_s_valid & r_rdy;
  assign o_s_ready = r_rdy;
  assign o_m_data  = r_out;
  assign o_m_valid = r_out_vld;

  always_comb begin
    w_skid_vld_n = r_skid_vld;
    if (w_drain)
      w_skid_vld_n = 1'b0;
    else if (w_take)
      w_skid_vld_n = 1'b1;
  end

  // Ready held low through reset and for the first cycle after release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out      <= '0;
      r_skid     <= '0;
      r_out_vld  <= 1'b0;
      r_skid_vld <= 1'b0;
      r_rdy      <= 1'b0;
    end else begin
      r_rdy      <= ~w_skid_vld_n;
      r_skid_vld <= w_skid_vld_n;
      if (w_drain) begin
        if (r_skid_vld) begin
          r_out     <= r_skid;
          r_out_vld <= 1'b1;
        end else begin
          r_out_vld <= w_take;
          if (w_take)
            r_out <= i_s_data;
        end
      end else if (w_take) begin
        r_skid <= i_s_data;
      end
    end
  end

endmodule

// File: rtl/rx_port_arbiter.sv
// Packet-granular round-robin merge of NUM_PORTS RX AXI-Stream queues into one
// 64-bit stream, tagging each beat with its source port and the bad-frame flag.
module rx_port_arbiter
  import rx_port_arbiter_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = AXIS_DATA_W,
  parameter int PORT_W     = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   s_tdata,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] s_tstrb,
  input  logic [NUM_PORTS-1:0]              s_tvalid,
  input  logic [NUM_PORTS-1:0]              s_tlast,
  input  logic [NUM_PORTS-1:0]              s_err,
  output logic [NUM_PORTS-1:0]              s_tready,
  output logic [DATA_WIDTH-1:0]             m_tdata,
  output logic [DATA_WIDTH/8-1:0]           m_tstrb,
  output logic                              m_tvalid,
  output logic                              m_tlast,
  output logic [PORT_W-1:0]                 m_tuser,
  output logic                              m_err,
  input  logic                              m_tready
);

  localparam int STRB_W = AXIS_STRB_W * DATA_WIDTH / AXIS_DATA_W;
  localparam int BUF_W  = DATA_WIDTH + STRB_W + 1 + PORT_W + 1;
  localparam logic [PORT_W:0] NP_W = (PORT_W+1)'(NUM_PORTS);

  arb_state_e                 r_state;
  logic [PORT_W-1:0]          r_rr_ptr;
  logic [PORT_W-1:0]          r_cur_port;

  logic [2*NUM_PORTS-1:0]     w_req2;
  logic [NUM_PORTS-1:0]       w_rot;
  logic [PORT_W-1:0]          w_ofs;
  logic [PORT_W:0]            w_sum;
  logic [PORT_W-1:0]          w_grant;
  logic                       w_req_any;
  logic [PORT_W-1:0]          w_sel;
  logic                       w_gnt_ok;

  logic [DATA_WIDTH-1:0]      w_data;
  logic [STRB_W-1:0]          w_strb;
  logic                       w_valid;
  logic                       w_last;
  logic                       w_err;
  logic                       w_acc;
  logic                       w_buf_rdy;
  logic [BUF_W-1:0]           w_buf_in;
  logic [BUF_W-1:0]           w_buf_out;

  // Rotate requests so rr_ptr sits at bit 0, pick the lowest set bit, rotate back.
  assign w_req2 = {s_tvalid, s_tvalid} >> r_rr_ptr;
  assign w_rot  = w_req2[NUM_PORTS-1:0];

  always_comb begin
    w_ofs     = '0;
    w_req_any = 1'b0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_ofs     = PORT_W'(k);
        w_req_any = 1'b1;
      end
    end
  end

  assign w_sum   = {1'b0, r_rr_ptr} + {1'b0, w_ofs};
  assign w_grant = (w_sum >= NP_W) ? PORT_W'(w_sum - NP_W) : PORT_W'(w_sum);

  assign w_sel    = (r_state == ARB_ST_ARB) ? w_grant : r_cur_port;
  assign w_gnt_ok = (r_state == ARB_ST_PKT) | w_req_any;

  always_comb begin
    w_data  = '0;
    w_strb  = '0;
    w_valid = 1'b0;
    w_last  = 1'b0;
    w_err   = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_sel == PORT_W'(i)) begin
        w_data  = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        w_strb  = s_tstrb[i*STRB_W +: STRB_W];
        w_valid = s_tvalid[i];
        w_last  = s_tlast[i];
        w_err   = s_err[i];
      end
    end
  end

  // Ready is combinational so the first beat of a grant moves in the arbitration cycle.
  always_comb begin
    s_tready = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      s_tready[i] = w_buf_rdy & w_gnt_ok & (w_sel == PORT_W'(i));
  end

  assign w_acc    = w_valid & w_buf_rdy & w_gnt_ok;
  assign w_buf_in = {w_data, w_strb, w_last, w_sel, w_err & w_last};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ARB_ST_ARB;
      r_rr_ptr   <= '0;
      r_cur_port <= '0;
    end else begin
      case (r_state)
        ARB_ST_ARB: begin
          if (w_acc) begin
            r_cur_port <= w_grant;
            if (w_last)
              r_rr_ptr <= PORT_W'(rr_next(int'(w_grant), NUM_PORTS));
            else
              r_state <= ARB_ST_PKT;
          end
        end
        ARB_ST_PKT: begin
          if (w_acc && w_last) begin
            r_rr_ptr <= PORT_W'(rr_next(int'(r_cur_port), NUM_PORTS));
            r_state  <= ARB_ST_ARB;
          end
        end
        default: r_state <= ARB_ST_ARB;
      endcase
    end
  end

  axis_skid_buffer #(.WIDTH(BUF_W)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .i_s_data  (w_buf_in),
    .i_s_valid (w_acc),
    .o_s_ready (w_buf_rdy),
    .o_m_data  (w_buf_out),
    .o_m_valid (m_tvalid),
    .i_m_ready (m_tready)
  );

  assign {m_tdata, m_tstrb, m_tlast, m_tuser, m_err} = w_buf_out;

endmodule
